// File: rtl/envelope_shaper_pkg.sv
// envelope_shaper_pkg: shared state encoding, level limits and step helper
package envelope_shaper_pkg;
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_e;
  localparam int LEVEL_MAX = 255;
  localparam int STEP_W = 5;
  function automatic logic [STEP_W-1:0] rate_step(input logic [3:0] rate);
    return {1'b0, rate} + 5'd1;
  endfunction
endpackage

// File: rtl/envelope_shaper_tick_divider.sv
// tick_divider: free-running prescaler emitting a one-cycle tick every PRESCALE clocks
module tick_divider #(
  parameter int PRESCALE = 256
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = $clog2(PRESCALE);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(PRESCALE - 1);
  assign cnt_d = tick ? '0 : cnt_q + W'(1);
  // counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/envelope_shaper.sv
// envelope_shaper: ADSR envelope generator scaling a tone sample by the envelope level
module envelope_shaper
  import envelope_shaper_pkg::*;
#(
  parameter int PRESCALE = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gate,
  input  logic [7:0] sample_in,
  input  logic [3:0] attack_rate,
  input  logic [3:0] decay_rate,
  input  logic [3:0] release_rate,
  input  logic [7:0] sustain_level,
  output logic [7:0] sample_out,
  output logic [7:0] env_level,
  output logic       active
);
  logic tick;
  state_e state_q, state_d;
  logic [7:0] level_q, level_d, sample_out_q;
  logic [STEP_W-1:0] a_step, d_step, r_step;
  logic [8:0] up_sum, dec_lim;
  logic up_sat;
  logic [15:0] prod;
  tick_divider #(.PRESCALE(PRESCALE)) u_tick (.clk(clk), .reset(reset), .tick(tick));
  assign a_step = rate_step(attack_rate);
  assign d_step = rate_step(decay_rate);
  assign r_step = rate_step(release_rate);
  assign up_sum = {1'b0, level_q} + {4'b0, a_step};
  assign up_sat = up_sum >= 9'(LEVEL_MAX);
  assign dec_lim = {1'b0, sustain_level} + {4'b0, d_step};
  assign prod = {8'b0, sample_in} * {8'b0, level_q};
  // next state and level: gate-driven transitions take priority over tick-driven level steps
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      IDLE: state_d = gate ? ATTACK : IDLE;
      ATTACK:
        if (!gate) state_d = RELEASE;
        else if (tick) begin
          level_d = up_sat ? 8'(LEVEL_MAX) : up_sum[7:0];
          state_d = up_sat ? DECAY : ATTACK;
        end
      DECAY:
        if (!gate) state_d = RELEASE;
        else if (tick) begin
          level_d = ({1'b0, level_q} <= dec_lim) ? sustain_level : level_q - {3'b0, d_step};
          state_d = ({1'b0, level_q} <= dec_lim) ? SUSTAIN : DECAY;
        end
      SUSTAIN: state_d = gate ? SUSTAIN : RELEASE;
      RELEASE:
        if (gate) state_d = ATTACK;
        else if (tick) begin
          level_d = (level_q <= {3'b0, r_step}) ? '0 : level_q - {3'b0, r_step};
          state_d = (level_q <= {3'b0, r_step}) ? IDLE : RELEASE;
        end
      default: begin
        state_d = IDLE;
        level_d = '0;
      end
    endcase
  end
  // state, level and scaled-sample registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      sample_out_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      sample_out_q <= prod[15:8];
    end
  end
  assign sample_out = sample_out_q;
  assign env_level = level_q;
  assign active = state_q != IDLE;
endmodule

// File: tb/tb_envelope_shaper.sv
// tb_envelope_shaper: directed and randomized checks against a behavioural envelope model
module tb_envelope_shaper;
  localparam int P = 4;
  logic clk = 0, reset = 1, gate = 0;
  logic [7:0] sample_in = 0, sustain_level = 0;
  logic [3:0] attack_rate = 0, decay_rate = 0, release_rate = 0;
  logic [7:0] sample_out, env_level;
  logic active;
  envelope_shaper #(.PRESCALE(P)) dut (
    .clk(clk), .reset(reset), .gate(gate), .sample_in(sample_in),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .release_rate(release_rate),
    .sustain_level(sustain_level), .sample_out(sample_out), .env_level(env_level),
    .active(active)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  int m_cnt = 0, m_lvl = 0, m_ph = 0, m_out = 0;
  bit chk_en = 0;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // model phases: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  always @(posedge clk) begin : model
    bit tk;
    int t;
    if (reset) begin
      m_cnt = 0; m_lvl = 0; m_ph = 0; m_out = 0; chk_en = 1;
    end else begin
      tk = (m_cnt == P - 1);
      m_cnt = (m_cnt + 1) % P;
      m_out = (int'(sample_in) * m_lvl) / 256;
      if (m_ph == 0) m_ph = gate ? 1 : 0;
      else if (!gate && m_ph != 4) m_ph = 4;
      else if (gate && m_ph == 4) m_ph = 1;
      else if (tk) begin
        if (m_ph == 1) begin
          t = m_lvl + int'(attack_rate) + 1;
          m_lvl = (t > 255) ? 255 : t;
          if (m_lvl == 255) m_ph = 2;
        end else if (m_ph == 2) begin
          t = m_lvl - int'(decay_rate) - 1;
          if (t <= int'(sustain_level)) begin
            m_lvl = int'(sustain_level);
            m_ph = 3;
          end else m_lvl = t;
        end else if (m_ph == 4) begin
          t = m_lvl - int'(release_rate) - 1;
          m_lvl = (t < 0) ? 0 : t;
          if (m_lvl == 0) m_ph = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("env_level", int'(env_level), m_lvl);
      check("active", int'(active), int'(m_ph != 0));
      check("sample_out", int'(sample_out), m_out);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_level(input string name, input int v, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(env_level) == v) break;
    end
    check(name, int'(env_level), v);
  endtask
  initial begin
    cyc(2);
    reset = 0;
    cyc(100);
    check("idle_level", int'(env_level), 0);
    check("idle_active", int'(active), 0);
    check("idle_out", int'(sample_out), 0);
    attack_rate = 15; decay_rate = 3; sustain_level = 200; gate = 1;
    wait_level("att16", 16, 10);
    wait_level("att240", 240, 70);
    wait_level("att255", 255, 8);
    wait_level("dec251", 251, 8);
    wait_level("dec203", 203, 60);
    wait_level("sus200", 200, 8);
    cyc(40);
    sustain_level = 50;
    cyc(20);
    check("sus_hold", int'(env_level), 200);
    release_rate = 7; gate = 0;
    wait_level("rel96", 96, 80);
    gate = 1;
    wait_level("retrig112", 112, 8);
    gate = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!active) break;
    end
    check("rel_done_active", int'(active), 0);
    check("rel_done_level", int'(env_level), 0);
    gate = 1;
    wait_level("att128", 128, 50);
    sample_in = 255;
    cyc(1);
    check("mul_255x128", int'(sample_out), 127);
    reset = 1;
    cyc(1);
    check("rst_out", int'(sample_out), 0);
    check("rst_level", int'(env_level), 0);
    check("rst_active", int'(active), 0);
    reset = 0;
    wait_level("fresh16", 16, 10);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom % 24 == 0) gate = ~gate;
      if ($urandom % 40 == 0) begin
        attack_rate = 4'($urandom); decay_rate = 4'($urandom); release_rate = 4'($urandom);
      end
      if ($urandom % 30 == 0) sustain_level = 8'($urandom);
      sample_in = 8'($urandom);
      reset = ($urandom % 400 == 0);
    end
    reset = 0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/envelope_shaper.md
ENVELOPE_SHAPER -- requirements
Module: envelope_shaper

Interface
REQ-001 Parameter PRESCALE, default 256, SHALL set the clock cycles per envelope tick (legal range 2..65535).
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 gate  input  1  SHALL be the note-on level: high means note held, low means note released.
REQ-005 sample_in  input  8  SHALL be the unsigned tone sample from the square-wave generator (square_out).
REQ-006 attack_rate, decay_rate, release_rate  input  4 each  SHALL each select step = rate+1 (range 1..16) per tick.
REQ-007 sustain_level  input  8  SHALL be the unsigned envelope level held during SUSTAIN.
REQ-008 sample_out  output  8  SHALL be the envelope-scaled sample, registered.
REQ-009 env_level  output  8  SHALL be the current envelope level, registered.
REQ-010 active  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-011 The tick counter SHALL free-run 0..PRESCALE-1, asserting tick for one cycle when count = PRESCALE-1, then wrapping to 0.
REQ-012 States SHALL be IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-013 IDLE: gate high -> ATTACK on the next edge; level stays 0.
REQ-014 ATTACK: on tick, level += attack step, saturating at 255; on reaching 255 -> DECAY.
REQ-015 DECAY: on tick, if level - step <= sustain_level (9-bit compare, no wrap) then level = sustain_level and -> SUSTAIN; else level -= step.
REQ-016 SUSTAIN: level SHALL hold; changes to sustain_level while in SUSTAIN SHALL NOT change level.
REQ-017 RELEASE: on tick, level -= release step, floored at 0; on reaching 0 -> IDLE.
REQ-018 gate low in ATTACK, DECAY or SUSTAIN SHALL -> RELEASE on the next edge, starting from the current level.
REQ-019 gate high in RELEASE SHALL -> ATTACK on the next edge, starting from the current level (retrigger, no reset to 0).
REQ-020 State transitions caused by gate SHALL occur on any cycle; level changes SHALL occur only on tick cycles.
REQ-021 If a gate transition and a tick coincide, the gate transition SHALL win and level SHALL be unchanged that cycle.
REQ-022 sample_out SHALL equal (sample_in * env_level) >> 8 (16-bit product, upper byte), registered with 1-cycle latency from sample_in/env_level.
REQ-023 env_level SHALL reflect the level register with no added latency; active SHALL be decoded from the state register.

Reset
REQ-024 reset high SHALL force state IDLE, level 0, tick counter 0, sample_out 0, env_level 0, active 0 at the next edge.
REQ-025 reset asserted mid-note SHALL abort the envelope with no RELEASE phase; after release of reset, gate high SHALL start a fresh ATTACK from 0.
REQ-026 reset SHALL take priority over gate and tick.

Structure
REQ-027 A shared package SHALL hold the state enum (3-bit encoding), LEVEL_MAX = 255, and the step width constant (5 bits).
REQ-028 The tick counter SHALL be a sub-module named tick_divider (ports clk, reset, tick; parameter PRESCALE).
REQ-029 The state machine, level arithmetic and output multiply SHALL reside in envelope_shaper.

Verification (PRESCALE=4)
REQ-030 reset 2 cycles, gate=0 -> sample_out=0, env_level=0, active=0 for 100 cycles.
REQ-031 gate=1, attack_rate=15 -> env_level 16, 32, ... 240 on successive ticks, then 255 on tick 16 (~64 cycles), state DECAY.
REQ-032 after REQ-031, decay_rate=3, sustain_level=200 -> level 251, 247, ... 203, then 200 on the next tick; holds at 200 with the gate high.
REQ-033 gate=0 at level 200, release_rate=7 -> level drops 8 per tick to 0 after 25 ticks; active falls on the same edge that state becomes IDLE.
REQ-034 gate re-raised in RELEASE at level 96, attack_rate=15 -> ATTACK resumes from 96 (next tick 112), with no dip to 0.
REQ-035 sample_in=255, env_level=128 -> sample_out=127 one cycle later; reset asserted at that point -> all outputs 0 on the next edge.
